// File: rtl/mat_alu.sv
// Matrix ALU: 16-slot register file of 4x4 x DW matrices with element-wise ops, transpose and matmul.
// States: IDLE waits for en_alu / accepts preloads, COMPUTE fills the result buffer, COMMIT writes it back.
module mat_alu #(
    parameter int DW    = 16,
    parameter int NSLOT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_alu,
    input  logic [2:0]    op,
    input  logic [3:0]    s1,
    input  logic [7:0]    s2,
    input  logic [3:0]    dest,
    output logic          done,
    output logic          busy,
    input  logic          ld_en,
    input  logic [7:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [7:0]    rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int NWORD = NSLOT * 16;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_MULI   = 3'b011;
    localparam logic [2:0] OP_ADDI   = 3'b100;
    localparam logic [2:0] OP_MATMUL = 3'b101;
    localparam logic [2:0] OP_TRANS  = 3'b110;
    localparam logic [2:0] OP_COPY   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    state_t          state_q;
    logic            done_q;
    logic [5:0]      cnt_q;
    logic [DW-1:0]   acc_q;
    logic [2:0]      op_q;
    logic [3:0]      s1_q;
    logic [7:0]      s2_q;
    logic [3:0]      dest_q;
    logic [DW-1:0]   rbuf_q [16];
    logic [DW-1:0]   mem_q  [NWORD];

    logic            start;
    logic [7:0]      a_addr;
    logic [7:0]      b_addr;
    logic [DW-1:0]   a_val;
    logic [DW-1:0]   b_val;
    logic [DW-1:0]   imm;
    logic [DW-1:0]   prod;
    logic [DW-1:0]   elem_d;
    logic [DW-1:0]   mac_d;

    // A floating or unknown start pulse must not launch an operation.
    assign start   = (en_alu === 1'b1);
    assign done    = done_q;
    assign busy    = (state_q != ST_IDLE);
    assign rd_data = mem_q[rd_addr];

    // Matmul step counter is {i[3:0], k[1:0]} with i = {r, c}.
    always_comb begin
        a_addr = {s1_q, cnt_q[3:0]};
        b_addr = {s2_q[3:0], cnt_q[3:0]};
        if (op_q == OP_MATMUL) begin
            a_addr = {s1_q, cnt_q[5:4], cnt_q[1:0]};
            b_addr = {s2_q[3:0], cnt_q[1:0], cnt_q[3:2]};
        end else if (op_q == OP_TRANS) begin
            a_addr = {s1_q, cnt_q[1:0], cnt_q[3:2]};
        end
        a_val = mem_q[a_addr];
        b_val = mem_q[b_addr];
        imm   = {{(DW-8){1'b0}}, s2_q};
        prod  = (op_q == OP_MULI) ? a_val * imm : a_val * b_val;
        mac_d = ((cnt_q[1:0] == 2'd0) ? '0 : acc_q) + prod;
        case (op_q)
            OP_ADD:  elem_d = a_val + b_val;
            OP_SUB:  elem_d = a_val - b_val;
            OP_MULI: elem_d = prod;
            OP_ADDI: elem_d = a_val + imm;
            default: elem_d = a_val;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            op_q    <= OP_NOP;
            s1_q    <= '0;
            s2_q    <= '0;
            dest_q  <= '0;
            for (int j = 0; j < 16; j++) rbuf_q[j] <= '0;
            for (int j = 0; j < NWORD; j++) mem_q[j] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ld_en) mem_q[ld_addr] <= ld_data;
                    if (start) begin
                        op_q    <= op;
                        s1_q    <= s1;
                        s2_q    <= s2;
                        dest_q  <= dest;
                        cnt_q   <= '0;
                        state_q <= (op == OP_NOP) ? ST_COMMIT : ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (op_q == OP_MATMUL) begin
                        acc_q <= mac_d;
                        if (cnt_q[1:0] == 2'd3) rbuf_q[cnt_q[5:2]] <= mac_d;
                        if (cnt_q == 6'd63) state_q <= ST_COMMIT;
                    end else begin
                        rbuf_q[cnt_q[3:0]] <= elem_d;
                        if (cnt_q[3:0] == 4'hf) state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (op_q != OP_NOP) begin
                        for (int j = 0; j < 16; j++) mem_q[{dest_q, j[3:0]}] <= rbuf_q[j];
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mat_alu.md
Name: mat_alu

Overview:
Matrix ALU sitting directly downstream of the instruction decode/exe engine. It consumes the decoded op/s1/s2/dest fields on a one-cycle en_alu pulse, computes over an internal matrix register file, and returns a one-cycle done pulse. The register file holds 16 slots, each a 4x4 matrix of 16-bit elements. A load port preloads the file and a read port is used for inspection.

Parameters:
DW, 16, element width in bits
NSLOT, 16, number of matrix slots; fixed at 16 by the 4-bit slot fields

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; asynchronous, active-high
en_alu  in  1  start pulse from the exe engine; only a clean 1'b1 counts, X/Z is treated as 0
op  in  3  operation code
s1  in  4  source slot A
s2  in  8  source slot B in s2[3:0], or unsigned immediate in s2[7:0]
dest  in  4  destination slot
done  out  1  one-cycle completion pulse
busy  out  1  high while not in IDLE
ld_en  in  1  preload write enable; honoured only in IDLE
ld_addr  in  8  preload word address = {slot, row[1:0], col[1:0]}
ld_data  in  16  preload data
rd_addr  in  8  inspection read address, same format as ld_addr
rd_data  out  16  combinational read of mem[rd_addr]

Behaviour:
- Reset (async, rst=1): state=IDLE; done=0; busy=0; all 256 memory words=0; step counter=0; result buffer=0. Reset mid-operation aborts the op with no commit and no done pulse.
- Storage: mem[256] x 16 bits. Element (r,c) of slot k is at address k*16 + r*4 + c. There is a 16-entry result buffer buf[r*4+c].
- Opcodes (A=M[s1], B=M[s2[3:0]], I=zero-extended s2[7:0]):
  - 000: NOP, no write.
  - 001: A+B.
  - 010: A-B.
  - 011: A*I.
  - 100: A+I.
  - 101: A x B (4x4 matrix multiply).
  - 110: transpose(A).
  - 111: copy A.
- Arithmetic: two's-complement, modulo 2^16. Products are truncated to the low 16 bits. The matmul accumulator is 16 bits and wraps.
- FSM states: IDLE, COMPUTE, COMMIT.
  - IDLE: on the edge where en_alu=1, latch op/s1/s2/dest and clear the counter. Go to COMMIT if op=000, else to COMPUTE. Accepting a start also clears any pending done.
  - COMPUTE, element-wise ops and transpose (001-100, 110, 111): one element per edge, index i=0..15, buf[i] <= f(A[i],B[i]). For transpose, buf[r*4+c] <= A[c*4+r]. After i=15, go to COMMIT.
  - COMPUTE, matmul (101): one MAC per edge over 64 edges, counter {i[3:0], k[1:0]}. Clear acc at k=0. buf[i] <= acc + A[r][k]*B[k][c] at k=3. After the 64th edge, go to COMMIT.
  - COMMIT: one edge writes all 16 buf entries to slot dest (skipped for NOP), sets done<=1, and goes to IDLE.
- All operand reads use the pre-commit memory, so dest==s1 or dest==s2 (in-place) gives the mathematically correct result.
- Latency: accept at edge t. Element-wise ops commit at t+17, matmul at t+65, NOP at t+1. done is high for exactly the one cycle after the commit edge.
- en_alu is ignored while busy. ld_en is ignored while busy. en_alu and ld_en together in IDLE: the load writes and the op is accepted in the same edge, and the op sees the newly loaded word.
- rd_data is always combinational, including during an op. It shows committed contents only.

Test Plan:
- Reset, then read all 256 addresses -> every word 0; done=0; busy=0. Assert rst during a matmul at step 30 -> no done, dest slot unchanged.
- Load M0=all 3, M1=all 5; op=001, s1=0, s2=0x01, dest=2 -> done 17 edges after accept; M2 all 8. Repeat with op=010 -> M2 all 0xFFFE.
- Load M0=identity scaled by 2, M1[r][c]=4r+c; op=101, s1=0, s2=0x01, dest=3 -> done at accept+65; M3[r][c]=2*(4r+c).
- op=011, s1=1, s2=0x07, dest=1 (in-place, M1[r][c]=4r+c) -> M1[r][c]=7*(4r+c). Then M1 element 0x4000 with imm 8 -> wraps to 0x0000.
- op=110 on M1 with dest=1 (in-place) -> M1 becomes the exact transpose. op=000 -> done at accept+1 and memory unchanged.
- Pulse en_alu and drive ld_en repeatedly while busy -> both ignored; exactly one done pulse, and an en_alu in the cycle done is high is accepted.
